// File: rtl/syndrome_packer_if.sv
// Handshake bundle between the syndrome source, the packer and the
// decoder input FIFO: one round port in, one byte port out.
interface syndrome_packer_if #(
    parameter int PU_PER_ROUND = 18
);
    logic [PU_PER_ROUND-1:0] round_data;
    logic                    round_valid;
    logic                    round_ready;
    logic [7:0]              output_data;
    logic                    output_valid;
    logic                    output_ready;

    modport master (
        output round_data,
        output round_valid,
        input  round_ready,
        input  output_data,
        input  output_valid,
        output output_ready
    );

    modport slave (
        input  round_data,
        input  round_valid,
        output round_ready,
        output output_data,
        output output_valid,
        input  output_ready
    );
endinterface

// File: rtl/syndrome_packer.sv
// Packs syndrome rounds into a byte stream: START once after reset,
// then per frame a HEADER followed by GRID_WIDTH_U rounds, LSB first.
module syndrome_packer #(
    parameter int          GRID_WIDTH_X            = 6,
    parameter int          GRID_WIDTH_Z            = 3,
    parameter int          GRID_WIDTH_U            = 5,
    parameter logic [7:0]  START_DECODING_MSG      = 8'h01,
    parameter logic [7:0]  MEASUREMENT_DATA_HEADER = 8'h02
) (
    input  logic                 clk,
    input  logic                 reset,
    syndrome_packer_if.slave     bus,
    output logic [15:0]          frames_sent
);
    localparam int PU   = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int BPR  = (PU + 7) >> 3;
    localparam int CAPW = BPR * 8;
    localparam int RIW  = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
    localparam int BIW  = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [RIW-1:0] RLAST = RIW'(GRID_WIDTH_U - 1);
    localparam logic [BIW-1:0] BLAST = BIW'(BPR - 1);

    typedef enum logic [1:0] {
        SEND_START,
        SEND_HEADER,
        WAIT_ROUND,
        SEND_BYTES
    } state_t;

    state_t          state_q;
    logic [RIW-1:0]  round_idx_q;
    logic [BIW-1:0]  byte_idx_q;
    logic [CAPW-1:0] cap_q;
    logic [15:0]     frames_q;
    logic [7:0]      odata_q;
    logic            ovalid_q;
    logic            rready_q;

    logic [CAPW-1:0] ext;
    logic            out_xfer;
    logic            in_xfer;

    assign ext      = CAPW'(bus.round_data);
    assign out_xfer = ovalid_q && bus.output_ready;
    assign in_xfer  = rready_q && bus.round_valid;

    assign bus.output_data  = odata_q;
    assign bus.output_valid = ovalid_q;
    assign bus.round_ready  = rready_q;
    assign frames_sent      = frames_q;

    // Frame sequencer; outputs are loaded alongside the state so they
    // never depend on the same-cycle handshake inputs. The capture
    // register shifts down one byte per sent byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEND_START;
            round_idx_q <= '0;
            byte_idx_q  <= '0;
            cap_q       <= '0;
            frames_q    <= '0;
            odata_q     <= START_DECODING_MSG;
            ovalid_q    <= 1'b1;
            rready_q    <= 1'b0;
        end else begin
            unique case (state_q)
                SEND_START: begin
                    if (out_xfer) begin
                        state_q <= SEND_HEADER;
                        odata_q <= MEASUREMENT_DATA_HEADER;
                    end
                end
                SEND_HEADER: begin
                    if (out_xfer) begin
                        state_q     <= WAIT_ROUND;
                        round_idx_q <= '0;
                        ovalid_q    <= 1'b0;
                        rready_q    <= 1'b1;
                    end
                end
                WAIT_ROUND: begin
                    if (in_xfer) begin
                        state_q    <= SEND_BYTES;
                        byte_idx_q <= '0;
                        cap_q      <= ext >> 8;
                        odata_q    <= ext[7:0];
                        ovalid_q   <= 1'b1;
                        rready_q   <= 1'b0;
                    end
                end
                SEND_BYTES: begin
                    if (out_xfer) begin
                        if (byte_idx_q != BLAST) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            odata_q    <= cap_q[7:0];
                            cap_q      <= cap_q >> 8;
                        end else if (round_idx_q != RLAST) begin
                            state_q     <= WAIT_ROUND;
                            round_idx_q <= round_idx_q + 1'b1;
                            ovalid_q    <= 1'b0;
                            rready_q    <= 1'b1;
                        end else begin
                            state_q  <= SEND_HEADER;
                            frames_q <= frames_q + 16'd1;
                            odata_q  <= MEASUREMENT_DATA_HEADER;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/syndrome_packer.md
SYNDROME_PACKER -- requirements
Module: syndrome_packer

Interface
REQ-001 Parameter GRID_WIDTH_X, default 6, stabiliser columns per round.
REQ-002 Parameter GRID_WIDTH_Z, default 3, stabiliser rows per round.
REQ-003 Parameter GRID_WIDTH_U, default 5, measurement rounds per decoding frame.
REQ-004 Parameter START_DECODING_MSG, default 8'h01, byte sent once after reset.
REQ-005 Parameter MEASUREMENT_DATA_HEADER, default 8'h02, byte that opens every frame.
REQ-006 Derived: PU_PER_ROUND = GRID_WIDTH_X*GRID_WIDTH_Z; BYTES_PER_ROUND = (PU_PER_ROUND+7)>>3; defaults 18 and 3.
REQ-007 clk  input  1  single clock; all logic on posedge.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 round_data  input  PU_PER_ROUND  one round of syndrome bits; bit index i*GRID_WIDTH_Z+j for column i, row j.
REQ-010 round_valid  input  1  round_data valid.
REQ-011 round_ready  output  1  packer accepts a round this cycle.
REQ-012 output_data  output  8  byte stream to the decoder input FIFO.
REQ-013 output_valid  output  1  output_data valid.
REQ-014 output_ready  input  1  downstream accepts byte.
REQ-015 frames_sent  output  16  count of completed frames, wraps at 2^16.

Function
REQ-016 A transfer occurs on either port only in a cycle where valid and ready are both 1 at posedge clk.
REQ-017 FSM states: SEND_START, SEND_HEADER, WAIT_ROUND, SEND_BYTES.
REQ-018 SEND_START: output_valid=1, output_data=START_DECODING_MSG; on transfer -> SEND_HEADER.
REQ-019 SEND_HEADER: output_valid=1, output_data=MEASUREMENT_DATA_HEADER; on transfer round_idx<=0 -> WAIT_ROUND.
REQ-020 WAIT_ROUND: round_ready=1, output_valid=0; on round transfer, capture round_data zero-extended to BYTES_PER_ROUND*8 bits, byte_idx<=0 -> SEND_BYTES.
REQ-021 SEND_BYTES: output_valid=1, output_data = captured bits [byte_idx*8 +: 8] (least-significant byte first, pad bits 0).
REQ-022 SEND_BYTES transfer with byte_idx < BYTES_PER_ROUND-1: byte_idx increments, stay.
REQ-023 Last byte transferred and round_idx < GRID_WIDTH_U-1: round_idx increments -> WAIT_ROUND.
REQ-024 Last byte transferred and round_idx == GRID_WIDTH_U-1: frames_sent increments -> SEND_HEADER.
REQ-025 round_ready is 0 in every state except WAIT_ROUND; no round is accepted while bytes are pending.
REQ-026 While output_valid=1 and output_ready=0, output_data and output_valid hold stable.
REQ-027 output_valid does not depend combinationally on output_ready; round_ready does not depend combinationally on round_valid.
REQ-028 Latency: round accepted at edge N -> first data byte valid in cycle after edge N; peak throughput one byte per cycle, BYTES_PER_ROUND+1 cycles per round.
REQ-029 Frame on wire = 1 header + GRID_WIDTH_U*BYTES_PER_ROUND data bytes (default 16); START appears only once per reset.
REQ-030 round_idx, byte_idx widths are $clog2 of their ranges, minimum 1 bit.

Reset
REQ-031 On reset: state=SEND_START, round_idx=0, byte_idx=0, capture register=0, frames_sent=0.
REQ-032 Outputs in the cycle after reset deasserts: output_valid=1, output_data=START_DECODING_MSG, round_ready=0.
REQ-033 Reset mid-frame discards the partial frame; the next bytes are START then HEADER.

Verification
REQ-034 Reset release, output_ready=1 constantly -> bytes 8'h01, 8'h02, then round_ready=1 with output_valid=0.
REQ-035 Five rounds with round_data=18'h3_FFFF, output_ready=1 -> 8'h02 then 5x{8'hFF,8'hFF,8'h03}, then 8'h02; frames_sent=1.
REQ-036 Single round with bit (i=2,j=1) set (bit 7), others 0 -> bytes 8'h80,8'h00,8'h00 for that round.
REQ-037 output_ready toggled randomly over 10 frames -> byte sequence is identical to the run with output_ready=1, no drops or duplicates, output_data stable while stalled; frames_sent=10.
REQ-038 Reset asserted after the 2nd data byte of round 3 -> next bytes 8'h01, 8'h02, frames_sent=0.
REQ-039 round_valid held at 1 continuously -> exactly one round is accepted per WAIT_ROUND visit; round_ready=0 throughout SEND_BYTES.
